uart_cfg_regfile_p: RTL and testbench
=====================================

# uart_cfg_regfile_p

Parametrised UART configuration register file with built-in TX and RX FIFOs, the next generation of the protocol-configuration block. It sits between the user register bus and the UART core and Tx protocol state machine. It holds frame, baud and address configuration and buffers transmit and receive data in FIFOs of configurable width and depth. It reports FIFO status and sticky overflow flags.

## Interface
Parameters:
- DATA_W, 8: data/register width; also the baud compare width.
- ADDR_W, 5: register address width.
- FIFO_DEPTH, 8: entries per FIFO; power of two, at least 2.

Ports:
- glb_clk  in  1  clock, rising edge.
- glb_rstn  in  1  reset glb_rstn, asynchronous, active-low; clock glb_clk.
- usr_valid  in  1  register access strobe, one access per cycle.
- usr_wnr  in  1  1 = write, 0 = read.
- usr_addr  in  ADDR_W  register address.
- usr_wdata  in  DATA_W  write data.
- usr_rdata  out  DATA_W  registered read data.
- core_tx_ren  in  1  TX FIFO pop from the Tx state machine.
- core_tx_data  out  DATA_W  TX FIFO head (show-ahead).
- core_rx_wen  in  1  RX FIFO push from the core.
- core_rx_data  in  DATA_W  received byte.
- tx_full, tx_empty, rx_full, rx_empty  out  1 each  FIFO status.
- cfg_txen, cfg_rxen  out  1 each  channel enables.
- cfg_parity  out  2  parity mode.
- cfg_stopbit  out  1  stop bit count select.
- cfg_baudcmp  out  DATA_W  baud compare value.
- cfg_slave_addr, cfg_self_addr  out  DATA_W each  address registers.
- irq  out  1  interrupt; present only with UART_CFG_IRQ_EN.

## Operation
- Register map, accessed when usr_valid=1:
  - 0: TXEN[0]
  - 1: RXEN[0]
  - 2: SLAVE_ADDR
  - 3: SELF_ADDR
  - 4: FRAME, where [1:0] is parity and [2] is stop
  - 5: BAUDCMP
  - 6: DATA port; a write pushes the TX FIFO and a read pops the RX FIFO.
  - 7: STATUS, read-only except the W1C bits: {tx_ovf[5], rx_ovf[4], rx_full[3], rx_empty[2], tx_full[1], tx_empty[0]}. Writing 1 to bit 5 or 4 clears it.
  - 8: IRQ_MASK[5:0] (macro only)
  - Unmapped addresses: writes are ignored; reads return 0.
- Registers 0–5 are read/write. Read-back zero-extends to DATA_W.
- FIFOs:
  - Circular buffers with pointers of log2(FIFO_DEPTH)+1 bits.
  - Full when the pointer MSBs differ and the LSBs are equal. Empty when the pointers are equal.
- TX push when full: data is dropped and tx_ovf is set, unless core_tx_ren occurs in the same cycle. In that case both the push and the pop happen and the count is unchanged.
- RX push (core_rx_wen) when full: the same rule applies, using rx_ovf and a same-cycle user DATA read.
- Pop when empty: ignored. For an RX read, usr_rdata returns 0.
- Push and pop in the same cycle on a non-empty, non-full FIFO: both happen and the count is unchanged.
- core_tx_data always shows the head entry. It is 0 after reset. It is undefined while empty; the bench must not check it then.
- A user write to STATUS that clears an ovf bit in the same cycle a new overflow occurs: the set wins.

## Timing
- All outputs reset to 0 except tx_empty=1 and rx_empty=1. FIFO pointers reset to 0.
- Write latency: a register updates on the rising edge of the strobe cycle, and the cfg_* output changes in the next cycle.
- Read latency: usr_rdata is valid 1 cycle after the strobe and holds until the next read.
- FIFO flags are registered combinations of the pointers; they update in the cycle after a push or pop.
- TX push to visibility: a byte written at edge N makes tx_empty=0 and core_tx_data valid after edge N.
- Reset asserted mid-operation empties both FIFOs immediately and clears all configuration. In-flight reads are lost.

## Configuration
- Macro: UART_CFG_IRQ_EN.
- Defined:
  - IRQ_MASK register at address 8.
  - irq = |(IRQ_MASK & {tx_ovf, rx_ovf, rx_full, ~rx_empty, tx_full, tx_empty}), registered, reset 0.
- Undefined:
  - No irq port.
  - Address 8 is unmapped and reads 0.

## Test plan
- Reset, then read addresses 0–7 → all return 0 except STATUS=0x05.
- Write SLAVE_ADDR=0x13, SELF_ADDR=0x12, FRAME=0x4F, BAUDCMP=0x48 → cfg_slave_addr=0x13, cfg_self_addr=0x12, cfg_parity=2'b11, cfg_stopbit=1, cfg_baudcmp=0x48. Read-back of FRAME returns 0x4F.
- Push 5..13 (9 bytes) to address 6 with FIFO_DEPTH=8 → tx_full after 8 pushes, tx_ovf=1. Popping 8 times gives core_tx_data 5..12 in order, and tx_empty=1 after the 8th pop.
- Loopback: the core pushes 0xA5 and 0x3C into RX → reads of address 6 return 0xA5 then 0x3C. A third read returns 0 and rx_empty stays 1.
- TX FIFO full with simultaneous push 0x77 and core_tx_ren → no overflow, the count stays 8, and 0x77 is popped last.
- With UART_CFG_IRQ_EN: IRQ_MASK=0x10, then an RX overflow → irq=1 one cycle later. Writing STATUS=0x10 → irq=0.

Source files
------------

// File: rtl/uart_cfg_regfile_p.sv
// uart_cfg_regfile_p: UART configuration register file with TX/RX FIFOs.
// Holds frame, baud and address configuration, buffers TX/RX data and
// reports FIFO status plus sticky overflow flags.
// Optional feature macro: UART_CFG_IRQ_EN adds IRQ_MASK (address 8) and irq.
//
// Handshake: every input strobe (usr_valid, core_tx_ren, core_rx_wen) is a
// single-cycle request sampled on the rising edge of glb_clk. There is no
// back-pressure. A push into a full FIFO is dropped and flagged, unless a pop
// happens in the same cycle. A pop from an empty FIFO is ignored.

// Circular FIFO with extra-MSB pointers, show-ahead head, registered flags.
module uart_cfg_regfile_p_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty,
  output logic         ovf_evt
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_nxt;
  logic [PW-1:0] rd_nxt;
  logic          do_push;
  logic          do_pop;

  // Pop only when data exists. A full FIFO still accepts a push if the
  // same cycle frees a slot.
  always_comb begin
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    ovf_evt = push && full && !do_pop;
    wr_nxt  = wr_ptr + {{(PW-1){1'b0}}, do_push};
    rd_nxt  = rd_ptr + {{(PW-1){1'b0}}, do_pop};
  end

  // Storage, pointers and flags derived from the next pointer values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
      wr_ptr <= wr_nxt;
      rd_ptr <= rd_nxt;
      full   <= (wr_nxt[AW] != rd_nxt[AW]) && (wr_nxt[AW-1:0] == rd_nxt[AW-1:0]);
      empty  <= (wr_nxt == rd_nxt);
    end
  end

  assign head = mem[rd_ptr[AW-1:0]];
endmodule

module uart_cfg_regfile_p #(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 5,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              glb_clk,
  input  logic              glb_rstn,
  input  logic              usr_valid,
  input  logic              usr_wnr,
  input  logic [ADDR_W-1:0] usr_addr,
  input  logic [DATA_W-1:0] usr_wdata,
  output logic [DATA_W-1:0] usr_rdata,
  input  logic              core_tx_ren,
  output logic [DATA_W-1:0] core_tx_data,
  input  logic              core_rx_wen,
  input  logic [DATA_W-1:0] core_rx_data,
  output logic              tx_full,
  output logic              tx_empty,
  output logic              rx_full,
  output logic              rx_empty,
  output logic              cfg_txen,
  output logic              cfg_rxen,
  output logic [1:0]        cfg_parity,
  output logic              cfg_stopbit,
  output logic [DATA_W-1:0] cfg_baudcmp,
  output logic [DATA_W-1:0] cfg_slave_addr,
`ifdef UART_CFG_IRQ_EN
  output logic              irq,
`endif
  output logic [DATA_W-1:0] cfg_self_addr
);
  localparam logic [ADDR_W-1:0] A_TXEN   = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] A_RXEN   = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] A_SLAVE  = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] A_SELF   = ADDR_W'(3);
  localparam logic [ADDR_W-1:0] A_FRAME  = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] A_BAUD   = ADDR_W'(5);
  localparam logic [ADDR_W-1:0] A_DATA   = ADDR_W'(6);
  localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(7);
`ifdef UART_CFG_IRQ_EN
  localparam logic [ADDR_W-1:0] A_IRQMSK = ADDR_W'(8);
`endif

  logic              txen_q;
  logic              rxen_q;
  logic [DATA_W-1:0] slave_q;
  logic [DATA_W-1:0] self_q;
  logic [DATA_W-1:0] frame_q;
  logic [DATA_W-1:0] baud_q;
  logic              tx_ovf_q;
  logic              rx_ovf_q;
  logic              wr_en;
  logic              rd_en;
  logic              tx_push;
  logic              rx_pop;
  logic              tx_ovf_evt;
  logic              rx_ovf_evt;
  logic [DATA_W-1:0] rx_head;
  logic [5:0]        status_vec;
  logic [DATA_W-1:0] rd_mux;
`ifdef UART_CFG_IRQ_EN
  logic [5:0]        irq_mask_q;
  logic              irq_q;
`endif

  // Decode the user access into FIFO push/pop strobes.
  always_comb begin
    wr_en   = usr_valid && usr_wnr;
    rd_en   = usr_valid && !usr_wnr;
    tx_push = wr_en && (usr_addr == A_DATA);
    rx_pop  = rd_en && (usr_addr == A_DATA);
  end

  uart_cfg_regfile_p_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk     (glb_clk),
    .rstn    (glb_rstn),
    .push    (tx_push),
    .pop     (core_tx_ren),
    .wdata   (usr_wdata),
    .head    (core_tx_data),
    .full    (tx_full),
    .empty   (tx_empty),
    .ovf_evt (tx_ovf_evt)
  );

  uart_cfg_regfile_p_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk     (glb_clk),
    .rstn    (glb_rstn),
    .push    (core_rx_wen),
    .pop     (rx_pop),
    .wdata   (core_rx_data),
    .head    (rx_head),
    .full    (rx_full),
    .empty   (rx_empty),
    .ovf_evt (rx_ovf_evt)
  );

  assign status_vec = {tx_ovf_q, rx_ovf_q, rx_full, rx_empty, tx_full, tx_empty};

  // Read data selection; unmapped addresses and an empty RX pop read as 0.
  always_comb begin
    rd_mux = '0;
    case (usr_addr)
      A_TXEN:   rd_mux = DATA_W'(txen_q);
      A_RXEN:   rd_mux = DATA_W'(rxen_q);
      A_SLAVE:  rd_mux = slave_q;
      A_SELF:   rd_mux = self_q;
      A_FRAME:  rd_mux = frame_q;
      A_BAUD:   rd_mux = baud_q;
      A_DATA:   rd_mux = rx_empty ? '0 : rx_head;
      A_STATUS: rd_mux = DATA_W'(status_vec);
`ifdef UART_CFG_IRQ_EN
      A_IRQMSK: rd_mux = DATA_W'(irq_mask_q);
`endif
      default:  rd_mux = '0;
    endcase
  end

  // Configuration registers, sticky overflow flags and registered read data.
  always_ff @(posedge glb_clk or negedge glb_rstn) begin
    if (!glb_rstn) begin
      txen_q    <= 1'b0;
      rxen_q    <= 1'b0;
      slave_q   <= '0;
      self_q    <= '0;
      frame_q   <= '0;
      baud_q    <= '0;
      tx_ovf_q  <= 1'b0;
      rx_ovf_q  <= 1'b0;
      usr_rdata <= '0;
    end else begin
      if (wr_en) begin
        case (usr_addr)
          A_TXEN:  txen_q  <= usr_wdata[0];
          A_RXEN:  rxen_q  <= usr_wdata[0];
          A_SLAVE: slave_q <= usr_wdata;
          A_SELF:  self_q  <= usr_wdata;
          A_FRAME: frame_q <= usr_wdata;
          A_BAUD:  baud_q  <= usr_wdata;
          default: ;
        endcase
      end
      // A new overflow in the same cycle as a W1C clear keeps the flag set.
      if (tx_ovf_evt)
        tx_ovf_q <= 1'b1;
      else if (wr_en && (usr_addr == A_STATUS) && usr_wdata[5])
        tx_ovf_q <= 1'b0;
      if (rx_ovf_evt)
        rx_ovf_q <= 1'b1;
      else if (wr_en && (usr_addr == A_STATUS) && usr_wdata[4])
        rx_ovf_q <= 1'b0;
      if (rd_en) usr_rdata <= rd_mux;
    end
  end

`ifdef UART_CFG_IRQ_EN
  // Interrupt mask register and registered masked-status interrupt.
  always_ff @(posedge glb_clk or negedge glb_rstn) begin
    if (!glb_rstn) begin
      irq_mask_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      if (wr_en && (usr_addr == A_IRQMSK)) irq_mask_q <= usr_wdata[5:0];
      irq_q <= |(irq_mask_q & {tx_ovf_q, rx_ovf_q, rx_full, ~rx_empty, tx_full, tx_empty});
    end
  end

  assign irq = irq_q;
`endif

  assign cfg_txen       = txen_q;
  assign cfg_rxen       = rxen_q;
  assign cfg_slave_addr = slave_q;
  assign cfg_self_addr  = self_q;
  assign cfg_parity     = frame_q[1:0];
  assign cfg_stopbit    = frame_q[2];
  assign cfg_baudcmp    = baud_q;
endmodule

// File: tb/tb_uart_cfg_regfile_p.sv
// tb_uart_cfg_regfile_p: self-checking bench for uart_cfg_regfile_p.
// Optional feature macro: UART_CFG_IRQ_EN enables the irq checks.
module tb_uart_cfg_regfile_p;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 8;

  logic              glb_clk;
  logic              glb_rstn;
  logic              usr_valid;
  logic              usr_wnr;
  logic [ADDR_W-1:0] usr_addr;
  logic [DATA_W-1:0] usr_wdata;
  logic [DATA_W-1:0] usr_rdata;
  logic              core_tx_ren;
  logic [DATA_W-1:0] core_tx_data;
  logic              core_rx_wen;
  logic [DATA_W-1:0] core_rx_data;
  logic              tx_full, tx_empty, rx_full, rx_empty;
  logic              cfg_txen, cfg_rxen, cfg_stopbit;
  logic [1:0]        cfg_parity;
  logic [DATA_W-1:0] cfg_baudcmp, cfg_slave_addr, cfg_self_addr;
`ifdef UART_CFG_IRQ_EN
  logic              irq;
`endif

  int n_total = 0;
  int n_bad   = 0;

  logic [DATA_W-1:0] exp_q[$];     // expected usr_rdata per read
  logic [DATA_W-1:0] tx_model[$];  // TX FIFO reference contents
  logic [DATA_W-1:0] rx_model[$];  // RX FIFO reference contents

  uart_cfg_regfile_p #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .FIFO_DEPTH(DEPTH)) dut (
    .glb_clk        (glb_clk),
    .glb_rstn       (glb_rstn),
    .usr_valid      (usr_valid),
    .usr_wnr        (usr_wnr),
    .usr_addr       (usr_addr),
    .usr_wdata      (usr_wdata),
    .usr_rdata      (usr_rdata),
    .core_tx_ren    (core_tx_ren),
    .core_tx_data   (core_tx_data),
    .core_rx_wen    (core_rx_wen),
    .core_rx_data   (core_rx_data),
    .tx_full        (tx_full),
    .tx_empty       (tx_empty),
    .rx_full        (rx_full),
    .rx_empty       (rx_empty),
    .cfg_txen       (cfg_txen),
    .cfg_rxen       (cfg_rxen),
    .cfg_parity     (cfg_parity),
    .cfg_stopbit    (cfg_stopbit),
    .cfg_baudcmp    (cfg_baudcmp),
    .cfg_slave_addr (cfg_slave_addr),
`ifdef UART_CFG_IRQ_EN
    .irq            (irq),
`endif
    .cfg_self_addr  (cfg_self_addr)
  );

  // Clock
  initial glb_clk = 1'b0;
  always #5 glb_clk = ~glb_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: each accepted read is compared one cycle later.
  always @(posedge glb_clk) begin
    if (glb_rstn && usr_valid && !usr_wnr) begin
      @(negedge glb_clk);
      if (exp_q.size() == 0) chk("rd_unexpected", 1, 0);
      else chk("rdata", usr_rdata, exp_q.pop_front());
    end
  end

  // Driver tasks: inputs change on the falling edge.
  task automatic reg_write(input int addr, input logic [DATA_W-1:0] data);
    @(negedge glb_clk);
    usr_valid = 1'b1; usr_wnr = 1'b1; usr_addr = ADDR_W'(addr); usr_wdata = data;
    if (addr == 6) begin
      if (tx_model.size() < DEPTH) tx_model.push_back(data);
    end
    @(negedge glb_clk);
    usr_valid = 1'b0; usr_wnr = 1'b0;
  endtask

  task automatic reg_read(input int addr, input logic [DATA_W-1:0] exp);
    @(negedge glb_clk);
    usr_valid = 1'b1; usr_wnr = 1'b0; usr_addr = ADDR_W'(addr);
    exp_q.push_back(exp);
    @(negedge glb_clk);
    usr_valid = 1'b0;
  endtask

  // DATA read: expected value comes from the RX reference model.
  task automatic data_read();
    logic [DATA_W-1:0] e;
    e = (rx_model.size() == 0) ? '0 : rx_model.pop_front();
    reg_read(6, e);
  endtask

  task automatic tx_pop();
    @(negedge glb_clk);
    chk("tx_head", core_tx_data, tx_model[0]);
    core_tx_ren = 1'b1;
    void'(tx_model.pop_front());
    @(negedge glb_clk);
    core_tx_ren = 1'b0;
  endtask

  task automatic rx_push(input logic [DATA_W-1:0] data);
    @(negedge glb_clk);
    core_rx_wen = 1'b1; core_rx_data = data;
    if (rx_model.size() < DEPTH) rx_model.push_back(data);
    @(negedge glb_clk);
    core_rx_wen = 1'b0;
  endtask

  initial begin
    logic [DATA_W-1:0] e;
    glb_rstn = 1'b0; usr_valid = 1'b0; usr_wnr = 1'b0; usr_addr = '0; usr_wdata = '0;
    core_tx_ren = 1'b0; core_rx_wen = 1'b0; core_rx_data = '0;
    repeat (3) @(negedge glb_clk);
    chk("rst_tx_empty", tx_empty, 1);
    chk("rst_rx_empty", rx_empty, 1);
    chk("rst_tx_full", tx_full, 0);
    chk("rst_rx_full", rx_full, 0);
    chk("rst_rdata", usr_rdata, 0);
    chk("rst_tx_data", core_tx_data, 0);
    chk("rst_cfg", {cfg_txen, cfg_rxen, cfg_parity, cfg_stopbit, cfg_baudcmp,
                    cfg_slave_addr, cfg_self_addr}, 0);
`ifdef UART_CFG_IRQ_EN
    chk("rst_irq", irq, 0);
`endif
    glb_rstn = 1'b1;

    // Reset values of the register map
    for (int a = 0; a < 8; a++) reg_read(a, (a == 7) ? 8'h05 : 8'h00);
    reg_read(8, 8'h00);
    reg_read(9, 8'h00);

    // Configuration writes and read-back
    reg_write(2, 8'h13);
    reg_write(3, 8'h12);
    reg_write(4, 8'h4F);
    reg_write(5, 8'h48);
    reg_write(0, 8'hFF);
    reg_write(1, 8'h01);
    chk("cfg_slave", cfg_slave_addr, 8'h13);
    chk("cfg_self", cfg_self_addr, 8'h12);
    chk("cfg_parity", cfg_parity, 2'b11);
    chk("cfg_stop", cfg_stopbit, 1);
    chk("cfg_baud", cfg_baudcmp, 8'h48);
    chk("cfg_en", {cfg_txen, cfg_rxen}, 2'b11);
    reg_read(4, 8'h4F);
    reg_read(0, 8'h01);
    reg_write(9, 8'hAA);
    reg_read(9, 8'h00);

    // TX fill with overflow, then drain in order
    for (int i = 5; i <= 12; i++) reg_write(6, DATA_W'(i));
    chk("tx_full_8", tx_full, 1);
    reg_write(6, 8'd13);
    reg_read(7, 8'h26);
    for (int i = 0; i < DEPTH; i++) tx_pop();
    chk("tx_empty_drain", tx_empty, 1);
    reg_write(7, 8'h20);
    reg_read(7, 8'h05);

    // RX loopback, then a read of the empty FIFO
    rx_push(8'hA5);
    rx_push(8'h3C);
    chk("rx_not_empty", rx_empty, 0);
    data_read();
    data_read();
    data_read();
    chk("rx_empty_after", rx_empty, 1);

    // TX full with simultaneous push and pop
    for (int i = 0; i < DEPTH; i++) reg_write(6, DATA_W'($urandom_range(0, 255)));
    chk("tx_full_again", tx_full, 1);
    @(negedge glb_clk);
    chk("tx_head_sim", core_tx_data, tx_model[0]);
    usr_valid = 1'b1; usr_wnr = 1'b1; usr_addr = 6; usr_wdata = 8'h77; core_tx_ren = 1'b1;
    void'(tx_model.pop_front());
    tx_model.push_back(8'h77);
    @(negedge glb_clk);
    usr_valid = 1'b0; usr_wnr = 1'b0; core_tx_ren = 1'b0;
    chk("tx_full_sim", tx_full, 1);
    reg_read(7, 8'h06);
    for (int i = 0; i < DEPTH; i++) tx_pop();
    chk("tx_empty_sim", tx_empty, 1);

    // RX overflow, W1C collision, interrupt
`ifdef UART_CFG_IRQ_EN
    reg_write(8, 8'h10);
    reg_read(8, 8'h10);
`endif
    for (int i = 0; i < DEPTH; i++) rx_push(DATA_W'($urandom_range(0, 255)));
    chk("rx_full", rx_full, 1);
`ifdef UART_CFG_IRQ_EN
    chk("irq_pre_ovf", irq, 0);
`endif
    rx_push(8'hEE);
`ifdef UART_CFG_IRQ_EN
    chk("irq_same_cyc", irq, 0);
    @(negedge glb_clk);
    chk("irq_set", irq, 1);
`endif
    reg_read(7, 8'h19);
    // Clear attempt while another overflow lands: the flag stays set
    @(negedge glb_clk);
    usr_valid = 1'b1; usr_wnr = 1'b1; usr_addr = 7; usr_wdata = 8'h10;
    core_rx_wen = 1'b1; core_rx_data = 8'h99;
    @(negedge glb_clk);
    usr_valid = 1'b0; usr_wnr = 1'b0; core_rx_wen = 1'b0;
    reg_read(7, 8'h19);
    // Full RX with simultaneous user read and core push: no overflow
    reg_write(7, 8'h10);
    @(negedge glb_clk);
    e = rx_model.pop_front();
    rx_model.push_back(8'h42);
    usr_valid = 1'b1; usr_wnr = 1'b0; usr_addr = 6; core_rx_wen = 1'b1; core_rx_data = 8'h42;
    exp_q.push_back(e);
    @(negedge glb_clk);
    usr_valid = 1'b0; core_rx_wen = 1'b0;
    reg_read(7, 8'h09);
`ifdef UART_CFG_IRQ_EN
    chk("irq_clr", irq, 0);
`endif
    for (int i = 0; i < DEPTH; i++) data_read();
    data_read();
    chk("rx_empty_end", rx_empty, 1);

    // Asynchronous reset mid-operation
    reg_write(6, 8'h5A);
    reg_write(6, 8'hC3);
    rx_push(8'h11);
    @(negedge glb_clk);
    glb_rstn = 1'b0;
    #1;
    chk("mid_rst_tx_empty", tx_empty, 1);
    chk("mid_rst_rx_empty", rx_empty, 1);
    chk("mid_rst_tx_data", core_tx_data, 0);
    chk("mid_rst_cfg", {cfg_txen, cfg_rxen, cfg_parity, cfg_stopbit, cfg_baudcmp,
                        cfg_slave_addr, cfg_self_addr}, 0);
    tx_model.delete();
    rx_model.delete();
    @(negedge glb_clk);
    glb_rstn = 1'b1;
    reg_read(7, 8'h05);
    reg_read(2, 8'h00);

    repeat (2) @(negedge glb_clk);
    chk("rd_q_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
